// File: rtl/aib_tx_striper.sv
// aib_tx_striper: stripes an upstream word stream round-robin across the
// eligible AIB channels. Each channel owns a small first-word-fall-through
// FIFO that drains independently on its own valid/ready handshake.
module aib_tx_striper #(
  parameter int NumChannels = 6,
  parameter int DataWidth   = 72,
  parameter int FifoDepth   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DataWidth-1:0]   i_data,
  output logic                   o_tx_valid [NumChannels-1:0],
  input  logic                   i_tx_ready [NumChannels-1:0],
  output logic [DataWidth-1:0]   o_tx_data  [NumChannels-1:0],
  input  logic [2:0]             c_first_chn_id,
  input  logic [2:0]             c_last_chn_id,
  input  logic [NumChannels-1:0] c_chn_en,
  input  logic                   c_restart,
  output logic                   o_cfg_err,
  output logic                   o_busy,
  output logic [31:0]            o_word_cnt
);

  // FIFO address width; one extra pointer bit separates full from empty.
  localparam int AW = $clog2(FifoDepth);
  localparam int PW = AW + 1;

  // Channel FIFO storage (data only, never reset).
  logic [DataWidth-1:0]   r_mem  [NumChannels][FifoDepth];
  logic [PW-1:0]          r_wptr [NumChannels];
  logic [PW-1:0]          r_rptr [NumChannels];
  logic [2:0]             r_ptr;
  logic [31:0]            r_word_cnt;

  logic [NumChannels-1:0] w_elig;
  logic [NumChannels-1:0] w_sel;
  logic [NumChannels-1:0] w_empty;
  logic [NumChannels-1:0] w_full;
  logic [NumChannels-1:0] w_push;
  logic [NumChannels-1:0] w_pop;
  logic [NumChannels-1:0] w_tx_valid;
  logic                   w_any_elig;
  logic [2:0]             w_low_id;
  logic [2:0]             w_above_id;
  logic                   w_has_above;
  logic                   w_ptr_elig;
  logic                   w_ptr_full;
  logic                   w_ready;
  logic                   w_accept;
  logic [2:0]             w_next_ptr;

  // Channel eligibility from range and enable mask; loop bound covers id < NumChannels.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_elig[i] = c_chn_en[i] && (3'(i) >= c_first_chn_id) && (3'(i) <= c_last_chn_id);
    end
  end

  // Lowest eligible id and the lowest eligible id strictly above the stripe pointer.
  always_comb begin
    w_any_elig  = 1'b0;
    w_low_id    = '0;
    w_has_above = 1'b0;
    w_above_id  = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any_elig = 1'b1;
        w_low_id   = 3'(i);
        if (3'(i) > r_ptr) begin
          w_has_above = 1'b1;
          w_above_id  = 3'(i);
        end
      end
    end
  end

  // FIFO status from registered pointers only: MSB differs with equal address means full.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][PW-1] != r_rptr[i][PW-1]) &&
                   (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
    end
  end

  // Decode the stripe pointer and qualify the upstream handshake.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_sel[i] = (r_ptr == 3'(i));
    end
    w_ptr_elig = |(w_elig & w_sel);
    w_ptr_full = |(w_full & w_sel);
    w_ready    = w_ptr_elig && !w_ptr_full && !c_restart && !i_rst;
    w_accept   = i_valid && w_ready;
    w_push     = w_accept ? w_sel : '0;
  end

  // Downstream side: valid is masked during reset so nothing pops while it is held.
  always_comb begin
    w_tx_valid = '0;
    w_pop      = '0;
    for (int i = 0; i < NumChannels; i++) begin
      w_tx_valid[i]    = !w_empty[i] && !i_rst;
      w_pop[i]         = w_tx_valid[i] && i_tx_ready[i];
      o_tx_valid[i]    = w_tx_valid[i];
      o_tx_data[i]     = r_mem[i][r_rptr[i][AW-1:0]];
    end
  end

  // Stripe pointer next state: restart or an ineligible pointer rewinds, an accept advances.
  always_comb begin
    w_next_ptr = r_ptr;
    if (c_restart || !w_ptr_elig) begin
      if (w_any_elig) begin
        w_next_ptr = w_low_id;
      end
    end else if (w_accept) begin
      w_next_ptr = w_has_above ? w_above_id : w_low_id;
    end
  end

  // Control state: stripe pointer, FIFO pointers and the accepted-word counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_word_cnt <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      r_ptr <= w_next_ptr;
      if (w_accept) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      for (int i = 0; i < NumChannels; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PW'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PW'(1);
        end
      end
    end
  end

  // FIFO data write; the write address is the current write pointer of the selected channel.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NumChannels; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i][AW-1:0]] <= i_data;
      end
    end
  end

  assign o_ready    = w_ready;
  assign o_cfg_err  = !w_any_elig;
  assign o_busy     = !i_rst && !(&w_empty);
  assign o_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_aib_tx_striper.sv
// Directed bench for aib_tx_striper: a configuration vector table plus
// hand-written multi-cycle sequences. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_aib_tx_striper;
  localparam int NC = 6;
  localparam int DW = 72;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          tx_valid [NC-1:0];
  logic          tx_ready [NC-1:0];
  logic [DW-1:0] tx_data  [NC-1:0];
  logic [2:0]    first;
  logic [2:0]    last;
  logic [NC-1:0] en;
  logic          restart;
  logic          cfg_err;
  logic          busy;
  logic [31:0]   wcnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aib_tx_striper #(.NumChannels(NC), .DataWidth(DW), .FifoDepth(FD)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_data(data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .c_first_chn_id(first), .c_last_chn_id(last), .c_chn_en(en),
    .c_restart(restart), .o_cfg_err(cfg_err), .o_busy(busy), .o_word_cnt(wcnt)
  );

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
  } obs_t;

  typedef struct {
    logic [2:0]    first;
    logic [2:0]    last;
    logic [NC-1:0] en;
    logic          exp_err;
    logic          exp_rdy;
    int            exp_ch;
  } cfg_vec_t;

  obs_t     obs[$];
  bit       mon_en = 1'b0;
  bit       seen24 = 1'b0;
  cfg_vec_t tbl[10];

  // Record every word that leaves a channel, in exit order.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NC; i++) begin
        if (tx_valid[i] && tx_ready[i]) begin
          obs_t o;
          o.ch = i;
          o.d  = tx_data[i];
          obs.push_back(o);
        end
        if (tx_valid[i] && (i == 2 || i == 4)) seen24 = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] wd(int k);
    return {40'hAB_CDEF_0123, 32'(k)};
  endfunction

  function automatic logic [NC-1:0] vmask();
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = tx_valid[i];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++) tx_ready[i] = m[i];
  endtask

  task automatic do_reset();
    tick();
    rst     = 1'b1;
    valid   = 1'b0;
    restart = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int acc;
    int acc2;
    int exp_ch_b[8];
    logic [NC-1:0] em;

    exp_ch_b = '{0, 1, 3, 5, 0, 1, 3, 5};
    tbl[0] = '{3'd0, 3'd5, 6'h3F, 1'b0, 1'b1, 0};
    tbl[1] = '{3'd0, 3'd5, 6'h3E, 1'b0, 1'b1, 1};
    tbl[2] = '{3'd2, 3'd4, 6'h3F, 1'b0, 1'b1, 2};
    tbl[3] = '{3'd3, 3'd3, 6'h08, 1'b0, 1'b1, 3};
    tbl[4] = '{3'd4, 3'd1, 6'h3F, 1'b1, 1'b0, -1};
    tbl[5] = '{3'd0, 3'd5, 6'h00, 1'b1, 1'b0, -1};
    tbl[6] = '{3'd6, 3'd7, 6'h3F, 1'b1, 1'b0, -1};
    tbl[7] = '{3'd5, 3'd7, 6'h3F, 1'b0, 1'b1, 5};
    tbl[8] = '{3'd1, 3'd4, 6'h21, 1'b1, 1'b0, -1};
    tbl[9] = '{3'd1, 3'd4, 6'h30, 1'b0, 1'b1, 4};

    rst = 1'b1; valid = 1'b0; data = '0; first = 3'd0; last = 3'd5;
    en = 6'h3F; restart = 1'b0; set_rdy(6'h3F);
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", vmask(), '0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wcnt", wcnt, 32'd0);
    tick();
    rst = 1'b0;

    // Configuration table: rewind, push one word, see which channel gets it.
    exp_cnt = 0;
    for (int r = 0; r < 10; r++) begin
      first = tbl[r].first; last = tbl[r].last; en = tbl[r].en;
      restart = 1'b1; valid = 1'b0;
      tick();
      restart = 1'b0; valid = 1'b1; data = wd(100 + r);
      @(negedge clk);
      chk($sformatf("tbl%0d_cfg_err", r), cfg_err, tbl[r].exp_err);
      chk($sformatf("tbl%0d_ready", r), ready, tbl[r].exp_rdy);
      tick();
      valid = 1'b0;
      @(negedge clk);
      em = '0;
      if (tbl[r].exp_ch >= 0) begin
        em[tbl[r].exp_ch] = 1'b1;
        exp_cnt++;
        chk($sformatf("tbl%0d_data", r), tx_data[tbl[r].exp_ch], wd(100 + r));
      end
      chk($sformatf("tbl%0d_mask", r), vmask(), em);
      chk($sformatf("tbl%0d_wcnt", r), wcnt, 32'(exp_cnt));
      tick();
    end
    mon_en = 1'b1;

    // Full range, all ready: word k exits channel k mod 6.
    first = 3'd0; last = 3'd5; en = 6'h3F; set_rdy(6'h3F);
    do_reset();
    obs.delete();
    for (int k = 0; k < 12; k++) begin
      valid = 1'b1; data = wd(k);
      @(negedge clk);
      if (!ready) begin
        n_vec++; n_err++;
        $display("FAIL A_ready k=%0d: got 0 expected 1", k);
      end
      tick();
    end
    valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("A_nobs", obs.size(), 12);
    for (int k = 0; k < obs.size() && k < 12; k++) begin
      chk($sformatf("A_ch%0d", k), obs[k].ch, k % 6);
      chk($sformatf("A_d%0d", k), obs[k].d, wd(k));
    end
    chk("A_wcnt", wcnt, 32'd12);
    tick();

    // Degraded mask 0x2B: channels 2 and 4 skipped.
    en = 6'h2B;
    do_reset();
    obs.delete();
    seen24 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid = 1'b1; data = wd(k);
      tick();
    end
    valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("B_nobs", obs.size(), 8);
    for (int k = 0; k < obs.size() && k < 8; k++) begin
      chk($sformatf("B_ch%0d", k), obs[k].ch, exp_ch_b[k]);
      chk($sformatf("B_d%0d", k), obs[k].d, wd(k));
    end
    chk("B_ch2_ch4_quiet", seen24, 1'b0);
    tick();

    // Single stalled channel: fills after FifoDepth words, one pop admits one more.
    first = 3'd2; last = 3'd2; en = 6'h3F; set_rdy(6'h3B);
    do_reset();
    obs.delete();
    acc = 0;
    for (int j = 0; j < 10; j++) begin
      valid = 1'b1; data = wd(acc);
      @(negedge clk);
      if (ready) acc++;
      tick();
    end
    @(negedge clk);
    chk("C_accepted", acc, FD);
    chk("C_ready_full", ready, 1'b0);
    chk("C_busy", busy, 1'b1);
    chk("C_head_valid", tx_valid[2], 1'b1);
    chk("C_head_data", tx_data[2], wd(0));
    tick();
    acc2 = 0;
    for (int j = 0; j < 7; j++) begin
      tx_ready[2] = (j == 0);
      valid = 1'b1; data = wd(FD + acc2);
      @(negedge clk);
      if (ready) acc2++;
      tick();
    end
    @(negedge clk);
    chk("C_one_more", acc2, 1);
    chk("C_head_after_pop", tx_data[2], wd(1));
    chk("C_wcnt", wcnt, 32'd5);
    tick();
    valid = 1'b0; set_rdy(6'h3F);
    for (int j = 0; j < 6; j++) tick();
    @(negedge clk);
    chk("C_busy_drained", busy, 1'b0);
    chk("C_nobs", obs.size(), 5);
    for (int k = 0; k < obs.size() && k < 5; k++) begin
      chk($sformatf("C_order%0d", k), obs[k].d, wd(k));
    end
    tick();

    // Inverted range reports a config error and blocks; restoring it resumes at channel 1.
    first = 3'd4; last = 3'd1;
    do_reset();
    obs.delete();
    for (int j = 0; j < 3; j++) begin
      valid = 1'b1; data = wd(50 + j);
      @(negedge clk);
      chk($sformatf("D_cfg_err%0d", j), cfg_err, 1'b1);
      chk($sformatf("D_ready%0d", j), ready, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("D_no_push_mask", vmask(), '0);
    chk("D_no_push_wcnt", wcnt, 32'd0);
    tick();
    first = 3'd1; last = 3'd4; data = wd(77);
    @(negedge clk);
    chk("D_cfg_ok", cfg_err, 1'b0);
    chk("D_ready_realign", ready, 1'b0);
    tick();
    @(negedge clk);
    chk("D_ready_go", ready, 1'b1);
    tick();
    valid = 1'b0;
    tick();
    @(negedge clk);
    chk("D_nobs", obs.size(), 1);
    if (obs.size() > 0) begin
      chk("D_ch", obs[0].ch, 1);
      chk("D_d", obs[0].d, wd(77));
    end
    tick();

    // Restart rewinds to channel 0; reset mid-transfer discards buffered words.
    first = 3'd0; last = 3'd5; en = 6'h3F; set_rdy(6'h3F);
    do_reset();
    obs.delete();
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; data = wd(k);
      tick();
    end
    valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    chk("E_ready_restart", ready, 1'b0);
    tick();
    restart = 1'b0; valid = 1'b1; data = wd(3);
    @(negedge clk);
    chk("E_ready_after", ready, 1'b1);
    tick();
    valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("E_nobs", obs.size(), 4);
    for (int k = 0; k < obs.size() && k < 4; k++) begin
      chk($sformatf("E_ch%0d", k), obs[k].ch, (k == 3) ? 0 : k);
    end
    tick();
    set_rdy(6'h00);
    valid = 1'b1; data = wd(4);
    tick();
    data = wd(5);
    tick();
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("E_rst_mask", vmask(), '0);
    chk("E_rst_ready", ready, 1'b0);
    chk("E_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0; en = 6'h3C; set_rdy(6'h3F);
    obs.delete();
    valid = 1'b1; data = wd(9);
    @(negedge clk);
    chk("E_post_wcnt", wcnt, 32'd0);
    chk("E_post_mask", vmask(), '0);
    chk("E_post_busy", busy, 1'b0);
    chk("E_post_ready", ready, 1'b0);
    tick();
    @(negedge clk);
    chk("E_post_ready2", ready, 1'b1);
    tick();
    valid = 1'b0;
    tick();
    @(negedge clk);
    chk("E_post_nobs", obs.size(), 1);
    if (obs.size() > 0) begin
      chk("E_post_ch", obs[0].ch, 2);
      chk("E_post_d", obs[0].d, wd(9));
    end
    tick();

    // Word counter wraps from all-ones to zero.
    en = 6'h3F;
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_word_cnt;
    valid = 1'b1; data = wd(200);
    @(negedge clk);
    chk("F_preload", wcnt, 32'hFFFF_FFFF);
    chk("F_ready", ready, 1'b1);
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk("F_wrap", wcnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
